// File: rtl/msk_g16mul_rnd_feeder_if.sv
// Handshake/data bundle between the PRNG/controller and the randomness feeder.
interface msk_g16mul_rnd_feeder_if #(
  parameter int W = 4
);
  logic [W-1:0] rnd_in;
  logic         rnd_in_valid;
  logic         rnd_in_ready;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] rnd_ref;
  logic         ref_strobe;
  logic [W-1:0] rnd_mul;
  logic         mul_strobe;
  logic         res_valid;

  // Driver side: PRNG and request issuer.
  modport master (
    output rnd_in, rnd_in_valid, start_valid,
    input  rnd_in_ready, start_ready, rnd_ref, ref_strobe, rnd_mul, mul_strobe, res_valid
  );

  // Feeder side.
  modport slave (
    input  rnd_in, rnd_in_valid, start_valid,
    output rnd_in_ready, start_ready, rnd_ref, ref_strobe, rnd_mul, mul_strobe, res_valid
  );
endinterface

// File: rtl/msk_g16mul_rnd_feeder.sv
// Randomness feeder for a G(16) HPC1 masked multiplier: buffers PRNG words in
// a 4-deep FIFO and, per request, hands the older word to the refresh stage
// and (after the refresh latency) the newer word to the DOM multiplication.
module msk_g16mul_rnd_feeder #(
  parameter int d       = 2,
  parameter int NR      = 1,
  parameter int REF_LAT = 1,
  localparam int W      = 4 * NR
) (
  input logic                   clk,
  input logic                   syn_rst,
  msk_g16mul_rnd_feeder_if.slave bus
);

  if (REF_LAT < 0 || REF_LAT > 7 || d < 1 || NR < 1) begin : g_bad_param
    $error("msk_g16mul_rnd_feeder: illegal parameter set");
  end

  logic [W-1:0] mem [4];
  logic [1:0]   wr_ptr, rd_ptr;
  logic [2:0]   count;
  logic         push, fire;

  logic [W-1:0] mul_pipe [REF_LAT+1];
  logic [REF_LAT:0] vld_pipe;

  logic [W-1:0] rnd_ref_q, rnd_mul_q;
  logic         ref_strobe_q, mul_strobe_q, res_valid_q;

  // Ready flags decode the registered count only; a pop never frees a slot
  // for a push in the same cycle.
  assign bus.rnd_in_ready = (count < 3'd4);
  assign bus.start_ready  = (count >= 3'd2);

  assign push = bus.rnd_in_valid & bus.rnd_in_ready;
  assign fire = bus.start_valid & bus.start_ready;

  // FIFO storage; contents are don't-care once the count drops past them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.rnd_in;
  end

  // FIFO pointers/count: one push and a two-word pop may coincide.
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + {1'b0, push};
      rd_ptr <= rd_ptr + (fire ? 2'd2 : 2'd0);
      count  <= count + {2'b0, push} - (fire ? 3'd2 : 3'd0);
    end
  end

  // Refresh word goes out the cycle after the start; data is zero when idle.
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      rnd_ref_q    <= '0;
      ref_strobe_q <= 1'b0;
    end else begin
      rnd_ref_q    <= fire ? mem[rd_ptr] : '0;
      ref_strobe_q <= fire;
    end
  end

  // Multiplication word rides a (1+REF_LAT)-deep pipe so it lines up with the
  // multiplier's DOM stage; zero data travels with a cleared flag.
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      vld_pipe <= '0;
      for (int i = 0; i <= REF_LAT; i++) mul_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= fire;
      mul_pipe[0] <= fire ? mem[rd_ptr + 2'd1] : '0;
      for (int i = 1; i <= REF_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        mul_pipe[i] <= mul_pipe[i-1];
      end
    end
  end

  // Registered multiplication output and the result-valid marker one cycle later.
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      rnd_mul_q    <= '0;
      mul_strobe_q <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      rnd_mul_q    <= mul_pipe[REF_LAT];
      mul_strobe_q <= vld_pipe[REF_LAT];
      res_valid_q  <= mul_strobe_q;
    end
  end

  assign bus.rnd_ref    = rnd_ref_q;
  assign bus.ref_strobe = ref_strobe_q;
  assign bus.rnd_mul    = rnd_mul_q;
  assign bus.mul_strobe = mul_strobe_q;
  assign bus.res_valid  = res_valid_q;

endmodule

// File: tb/tb_msk_g16mul_rnd_feeder.sv
// Scoreboard bench for msk_g16mul_rnd_feeder (NR=1, REF_LAT=1).
module tb_msk_g16mul_rnd_feeder;
  localparam int NR = 1;
  localparam int REF_LAT = 1;
  localparam int W = 4 * NR;

  typedef struct {
    int           cyc;
    logic [W-1:0] w;
  } exp_t;

  logic clk = 1'b0;
  logic syn_rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   armed = 1'b0;

  exp_t ref_q[$];
  exp_t mul_q[$];
  exp_t res_q[$];
  logic [W-1:0] mq[$];

  msk_g16mul_rnd_feeder_if #(.W(W)) bus ();

  msk_g16mul_rnd_feeder #(.d(2), .NR(NR), .REF_LAT(REF_LAT)) dut (
    .clk(clk),
    .syn_rst(syn_rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus: check ready flags against the model, drive inputs
  // for the coming edge, then advance the model across that edge.
  task automatic step(input logic pv, input logic [W-1:0] w, input logic sv, input logic r);
    int   t;
    logic fire;
    @(posedge clk);
    #1;
    t = cyc;
    if (armed) begin
      chk("rnd_in_ready", {31'b0, bus.rnd_in_ready}, {31'b0, mq.size() < 4});
      chk("start_ready", {31'b0, bus.start_ready}, {31'b0, mq.size() >= 2});
    end
    bus.rnd_in       = w;
    bus.rnd_in_valid = pv;
    bus.start_valid  = sv;
    syn_rst          = r;
    if (r) begin
      mq.delete();
      while (ref_q.size() > 0 && ref_q[$].cyc > t) void'(ref_q.pop_back());
      while (mul_q.size() > 0 && mul_q[$].cyc > t) void'(mul_q.pop_back());
      while (res_q.size() > 0 && res_q[$].cyc > t) void'(res_q.pop_back());
    end else begin
      fire = sv && (mq.size() >= 2);
      if (pv && mq.size() < 4) begin
        if (fire) begin
          ref_q.push_back('{t + 1, mq.pop_front()});
          mul_q.push_back('{t + 3, mq.pop_front()});
          res_q.push_back('{t + 4, '0});
        end
        mq.push_back(w);
      end else if (fire) begin
        ref_q.push_back('{t + 1, mq.pop_front()});
        mul_q.push_back('{t + 3, mq.pop_front()});
        res_q.push_back('{t + 4, '0});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle each output channel is either the next expected
  // entry (due now) or strobe low with zero data.
  always @(negedge clk) begin
    if (armed) begin
      exp_t e;
      bit   due;
      due = (ref_q.size() > 0) && (ref_q[0].cyc == cyc);
      e = due ? ref_q.pop_front() : '{0, '0};
      chk("ref", {27'b0, bus.ref_strobe, bus.rnd_ref}, {27'b0, due, e.w});
      due = (mul_q.size() > 0) && (mul_q[0].cyc == cyc);
      e = due ? mul_q.pop_front() : '{0, '0};
      chk("mul", {27'b0, bus.mul_strobe, bus.rnd_mul}, {27'b0, due, e.w});
      due = (res_q.size() > 0) && (res_q[0].cyc == cyc);
      if (due) void'(res_q.pop_front());
      chk("res_valid", {31'b0, bus.res_valid}, {31'b0, due});
    end
  end

  initial begin
    bus.rnd_in = '0;
    bus.rnd_in_valid = 1'b0;
    bus.start_valid = 1'b0;
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 4'hF, 1'b1, 1'b1);   // handshakes during reset are ignored
    armed = 1'b1;
    idle(2);

    // Basic: A to refresh, 5 to multiplication.
    step(1'b1, 4'hA, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(6);

    // Streaming words with start held high.
    for (int i = 1; i <= 12; i++) step(1'b1, W'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(6);

    // Fill to 4, rejected push while full, then one start frees two slots.
    for (int i = 6; i <= 9; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    step(1'b1, 4'hE, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(5);

    // Count = 1 blocks the start until a second word arrives.
    step(1'b1, 4'h3, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 4'hC, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(5);

    // Back-to-back starts from a full FIFO.
    for (int i = 1; i <= 4; i++) step(1'b1, W'(i + 10), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(6);

    // Reset two cycles after a start drops the in-flight multiplication.
    step(1'b1, 4'hB, 1'b0, 1'b0);
    step(1'b1, 4'hD, 1'b0, 1'b0);
    step(1'b1, 4'h7, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    idle(6);

    chk("ref_q_drained", ref_q.size(), 0);
    chk("mul_q_drained", mul_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/msk_g16mul_rnd_feeder.md
MSK_G16MUL_RND_FEEDER -- requirements
Module: msk_g16mul_rnd_feeder

Interface
REQ-001 SHALL have parameter d, default 2: number of shares of the served G(16) HPC1 multiplier (informational, no effect on logic).
REQ-002 SHALL have parameter NR, default 1: random bits per nibble lane; word width W = 4*NR, used for both refresh and multiplication randomness.
REQ-003 SHALL have parameter REF_LAT, default 1: refresh-stage latency of the served multiplier, legal range 0..7.
REQ-004 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-005 SHALL have port syn_rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have ports rnd_in input [W-1:0], rnd_in_valid input 1, rnd_in_ready output 1: fresh-randomness word stream from the PRNG.
REQ-007 SHALL have ports start_valid input 1, start_ready output 1: one multiplication request per handshake.
REQ-008 SHALL have ports rnd_ref output [W-1:0], ref_strobe output 1: refresh randomness and its qualifier.
REQ-009 SHALL have ports rnd_mul output [W-1:0], mul_strobe output 1: DOM multiplication randomness and its qualifier.
REQ-010 SHALL have port res_valid output 1: pulse marking the multiplier output sharing valid.

Function
REQ-011 SHALL buffer words in a 4-entry in-order FIFO with count 0..4; a push occurs when rnd_in_valid && rnd_in_ready.
REQ-012 SHALL drive rnd_in_ready = (count < 4), computed from the registered count, with no bypass on simultaneous pop.
REQ-013 SHALL drive start_ready = (count >= 2); a start fires when start_valid && start_ready, popping exactly two words in the same cycle.
REQ-014 SHALL give the older popped word to refresh and the newer to multiplication.
REQ-015 SHALL allow push and start in the same cycle: count_next = count + 1 - 2; the pushed word never leaves in the same cycle.
REQ-016 For a start at cycle t: rnd_ref = ref word and ref_strobe = 1 at t+1.
REQ-017 For a start at cycle t: rnd_mul = mul word and mul_strobe = 1 at t+2+REF_LAT, delivered through a (1+REF_LAT)-deep word+flag shift pipeline.
REQ-018 For a start at cycle t: res_valid = 1 at t+3+REF_LAT, matching the multiplier's 2+REF_LAT output latency relative to rnd_ref.
REQ-019 SHALL support overlapping operations: any number of starts in flight, each pipeline slot independent; maximum start rate one per cycle while count >= 2.
REQ-020 SHALL drive rnd_ref and rnd_mul to all-zero in every cycle their strobe is 0; no word is ever presented twice or in two different roles.
REQ-021 SHALL register all outputs except rnd_in_ready and start_ready, which are decoded from registered count only.
REQ-022 SHALL NOT let a start with count < 2 pop, shift or strobe anything.

Reset
REQ-023 When syn_rst = 1 at an edge: FIFO count = 0, all pipeline flags = 0, and rnd_ref, rnd_mul = 0; ref_strobe, mul_strobe, res_valid = 0.
REQ-024 During reset cycles: rnd_in_ready = 1 and start_ready = 0 (count 0); handshakes in that cycle are ignored.
REQ-025 Reset mid-operation SHALL drop all in-flight operations (no later strobes) and discard buffered words, which are never emitted.

Verification (REF_LAT=1, NR=1)
REQ-026 Push 0xA then 0x5; start at t -> ref_strobe, rnd_ref=0xA at t+1; mul_strobe, rnd_mul=0x5 at t+3; res_valid at t+4; outputs zero otherwise.
REQ-027 Continuous rnd_in_valid with words 1,2,3,4,... and start_valid held high -> starts every second cycle once primed; pairs (1,2),(3,4),... in order with no word repeated or skipped.
REQ-028 Fill FIFO to 4 without starts -> rnd_in_ready = 0 while count = 4; a start drops count to 2 and rnd_in_ready returns to 1 the next cycle.
REQ-029 count = 1 with start_valid = 1 -> start_ready = 0, no strobes; a push makes start_ready = 1 next cycle.
REQ-030 Start at t, syn_rst at t+2 -> no mul_strobe at t+3, no res_valid at t+4; count = 0 and start_ready = 0 after reset.
REQ-031 Two starts at t and t+1 (count = 4 at t) -> ref strobes at t+1 and t+2, mul strobes at t+3 and t+4, res_valid at t+4 and t+5, words in FIFO order.
